// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage feeding the decoder.
// Holds the PC and issues single-outstanding requests to instruction memory.
// It presents one instruction at a time and honours decoder stall. A branch
// redirect squashes any fetch that is still in flight.
//
// Ports:
//   I_clk, I_rst             clock, synchronous active-high reset
//   I_en                     fetch enable (sampled in IDLE and when leaving HOLD)
//   I_stall                  decoder not ready; hold current instruction
//   I_branch, I_branch_pc    one-cycle redirect request and its target
//   O_imem_req, O_imem_addr  one-cycle request strobe and word address
//   I_imem_valid, I_imem_data  memory response strobe and data
//   O_inst, O_inst_valid, O_pc  instruction, valid/decoder enable, its PC
module inst_fetch #(
    parameter int                PC_W     = 16,
    parameter int                INST_W   = 16,
    parameter logic [PC_W-1:0]   RESET_PC = '0
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_en,
    input  logic              I_stall,
    input  logic              I_branch,
    input  logic [PC_W-1:0]   I_branch_pc,
    output logic              O_imem_req,
    output logic [PC_W-1:0]   O_imem_addr,
    input  logic              I_imem_valid,
    input  logic [INST_W-1:0] I_imem_data,
    output logic [INST_W-1:0] O_inst,
    output logic              O_inst_valid,
    output logic [PC_W-1:0]   O_pc
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t              state, state_n;
    logic [PC_W-1:0]     pc, pc_n;
    logic                squash, squash_n;
    logic [INST_W-1:0]   inst, inst_n;
    logic [PC_W-1:0]     inst_pc, inst_pc_n;
    logic                inst_valid, inst_valid_n;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            squash     <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            squash     <= squash_n;
            inst       <= inst_n;
            inst_pc    <= inst_pc_n;
            inst_valid <= inst_valid_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        squash_n     = squash;
        inst_n       = inst;
        inst_pc_n    = inst_pc;
        inst_valid_n = inst_valid;

        case (state)
            IDLE: begin
                // A redirect while idle only moves the PC; no fetch starts.
                if (I_branch) begin
                    pc_n = I_branch_pc;
                end else if (I_en) begin
                    state_n = REQ;
                end
            end

            REQ: begin
                // The request leaves this cycle regardless; a branch marks
                // its response for discard.
                state_n = WAIT;
                if (I_branch) begin
                    pc_n     = I_branch_pc;
                    squash_n = 1'b1;
                end
            end

            WAIT: begin
                if (I_branch) begin
                    pc_n = I_branch_pc;
                    if (I_imem_valid) begin
                        // Response consumed and dropped now, so nothing is
                        // left to squash; refetch at the target.
                        squash_n = 1'b0;
                        state_n  = REQ;
                    end else begin
                        squash_n = 1'b1;
                    end
                end else if (I_imem_valid) begin
                    if (squash) begin
                        squash_n = 1'b0;
                        state_n  = REQ;
                    end else begin
                        inst_n       = I_imem_data;
                        inst_pc_n    = pc;
                        inst_valid_n = 1'b1;
                        state_n      = HOLD;
                    end
                end
            end

            HOLD: begin
                // Branch wins over stall: the held instruction is dropped.
                if (I_branch) begin
                    inst_valid_n = 1'b0;
                    pc_n         = I_branch_pc;
                    state_n      = REQ;
                end else if (!I_stall) begin
                    inst_valid_n = 1'b0;
                    pc_n         = pc + PC_W'(1);
                    state_n      = I_en ? REQ : IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    assign O_imem_req   = (state == REQ);
    assign O_imem_addr  = pc;
    assign O_inst       = inst;
    assign O_inst_valid = inst_valid;
    assign O_pc         = inst_pc;

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard bench for inst_fetch.
// Expected request addresses and deliveries are queued as stimulus is set
// up. Monitors pop and compare them when the DUT issues a request or
// raises O_inst_valid. The memory model answers with data = addr + 16'hA123
// after a programmable number of cycles.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        en;
    logic        stall;
    logic        branch;
    logic [15:0] branch_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic [15:0] inst;
    logic        inst_valid;
    logic [15:0] pc;

    inst_fetch #(
        .PC_W    (16),
        .INST_W  (16),
        .RESET_PC(16'h0000)
    ) dut (
        .I_clk       (clk),
        .I_rst       (rst),
        .I_en        (en),
        .I_stall     (stall),
        .I_branch    (branch),
        .I_branch_pc (branch_pc),
        .O_imem_req  (imem_req),
        .O_imem_addr (imem_addr),
        .I_imem_valid(imem_valid),
        .I_imem_data (imem_data),
        .O_inst      (inst),
        .O_inst_valid(inst_valid),
        .O_pc        (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned deliv_cnt = 0;
    int unsigned mem_delay = 1;
    logic        mon_on = 1'b0;

    logic [15:0] req_q[$];
    logic [31:0] deliv_q[$];   // {inst, pc}

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_data(input logic [15:0] a);
        return a + 16'hA123;
    endfunction

    task automatic expect_fetch(input logic [15:0] a, input logic delivered);
        req_q.push_back(a);
        if (delivered) deliv_q.push_back({mem_data(a), a});
    endtask

    task automatic wait_deliv(input int unsigned target);
        for (int i = 0; i < 60; i++) begin
            if (deliv_cnt >= target) break;
            @(negedge clk);
        end
        check("deliv_timeout", {31'd0, deliv_cnt >= target}, 32'd1);
    endtask

    // Instruction memory: one outstanding request, answered after mem_delay cycles.
    initial begin
        int unsigned cnt;
        logic [15:0] addr_l;
        cnt        = 0;
        addr_l     = '0;
        imem_valid = 1'b0;
        imem_data  = '0;
        forever begin
            @(negedge clk);
            imem_valid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    imem_valid = 1'b1;
                    imem_data  = mem_data(addr_l);
                end
            end
            if (imem_req === 1'b1) begin
                addr_l = imem_addr;
                cnt    = mem_delay;
            end
        end
    end

    // Scoreboard monitors: requests and rising O_inst_valid.
    initial begin
        logic        prev_v;
        logic [15:0] ea;
        logic [31:0] ed;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (imem_req) begin
                    if (req_q.size() == 0) begin
                        check("req_unexpected", {16'd0, imem_addr}, 32'hFFFF_FFFF);
                    end else begin
                        ea = req_q.pop_front();
                        check("req_addr", {16'd0, imem_addr}, {16'd0, ea});
                    end
                end
                if (inst_valid && !prev_v) begin
                    deliv_cnt++;
                    if (deliv_q.size() == 0) begin
                        check("deliv_unexpected", {inst, pc}, 32'hFFFF_FFFF);
                    end else begin
                        ed = deliv_q.pop_front();
                        check("deliv_inst", {16'd0, inst}, {16'd0, ed[31:16]});
                        check("deliv_pc", {16'd0, pc}, {16'd0, ed[15:0]});
                    end
                end
                prev_v = inst_valid;
            end
        end
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        stall     = 1'b1;
        branch    = 1'b0;
        branch_pc = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_req",   {31'd0, imem_req}, 32'd0);
        check("rst_addr",  {16'd0, imem_addr}, 32'd0);
        check("rst_inst",  {16'd0, inst}, 32'd0);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_pc",    {16'd0, pc}, 32'd0);
        rst    = 1'b0;
        mon_on = 1'b1;

        // 1: first fetch from address 0, data A123
        expect_fetch(16'h0000, 1'b1);
        en = 1'b1;
        wait_deliv(1);
        check("t1_inst", {16'd0, inst}, 32'h0000_A123);

        // 2: stall holds everything, then release fetches address 1
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, inst_valid}, 32'd1);
            check("stall_inst",  {16'd0, inst}, 32'h0000_A123);
            check("stall_pc",    {16'd0, pc}, 32'd0);
            check("stall_noreq", {31'd0, imem_req}, 32'd0);
        end
        expect_fetch(16'h0001, 1'b1);
        stall = 1'b0;
        @(negedge clk);
        stall = 1'b1;
        wait_deliv(2);

        // 3: branch in WAIT, stale response arrives two cycles later
        expect_fetch(16'h0002, 1'b0);
        expect_fetch(16'h0040, 1'b1);
        mem_delay = 3;
        stall = 1'b0;
        @(negedge clk);              // REQ for address 2
        stall = 1'b1;
        @(negedge clk);              // first WAIT cycle, no response yet
        branch    = 1'b1;
        branch_pc = 16'h0040;
        mem_delay = 1;
        @(negedge clk);
        branch = 1'b0;
        wait_deliv(3);

        // 4: branch in HOLD together with stall
        expect_fetch(16'h0080, 1'b1);
        branch    = 1'b1;
        branch_pc = 16'h0080;
        @(negedge clk);
        branch = 1'b0;
        check("br_hold_valid", {31'd0, inst_valid}, 32'd0);
        check("br_hold_req",   {31'd0, imem_req}, 32'd1);
        check("br_hold_addr",  {16'd0, imem_addr}, 32'h0000_0080);
        wait_deliv(4);

        // 5: PC wraps from FFFF to 0000
        expect_fetch(16'hFFFF, 1'b1);
        branch    = 1'b1;
        branch_pc = 16'hFFFF;
        @(negedge clk);
        branch = 1'b0;
        wait_deliv(5);
        expect_fetch(16'h0000, 1'b1);
        stall = 1'b0;
        @(negedge clk);
        stall = 1'b1;
        wait_deliv(6);

        // 6: reset during WAIT, late response is ignored
        expect_fetch(16'h0001, 1'b0);
        mem_delay = 3;
        stall = 1'b0;
        @(negedge clk);              // REQ for address 1
        stall = 1'b1;
        @(negedge clk);              // WAIT
        rst       = 1'b1;
        en        = 1'b0;
        mem_delay = 1;
        @(negedge clk);
        rst = 1'b0;
        check("wrst_req",   {31'd0, imem_req}, 32'd0);
        check("wrst_addr",  {16'd0, imem_addr}, 32'd0);
        check("wrst_inst",  {16'd0, inst}, 32'd0);
        check("wrst_valid", {31'd0, inst_valid}, 32'd0);
        check("wrst_pc",    {16'd0, pc}, 32'd0);
        @(negedge clk);              // late response in IDLE
        @(negedge clk);
        check("late_valid", {31'd0, inst_valid}, 32'd0);
        check("late_req",   {31'd0, imem_req}, 32'd0);
        check("late_inst",  {16'd0, inst}, 32'd0);
        expect_fetch(16'h0000, 1'b1);
        en = 1'b1;
        wait_deliv(7);

        repeat (2) @(negedge clk);
        check("req_q_left",   req_q.size(), 32'd0);
        check("deliv_q_left", deliv_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
